// File: rtl/memory_ldst_frontend_if.sv
// Handshake bundle for memory_ldst_frontend: producer-side request channels,
// memory-side issue channels and the store-completion path.
interface memory_ldst_frontend_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              in_ldaddr_valid;
    logic              in_ldaddr_ready;
    logic [ADDR_W-1:0] in_ldaddr_data;
    logic              in_staddr_valid;
    logic              in_staddr_ready;
    logic [ADDR_W-1:0] in_staddr_data;
    logic              in_stdata_valid;
    logic              in_stdata_ready;
    logic [DATA_W-1:0] in_stdata_data;
    logic              ldaddr_valid;
    logic              ldaddr_ready;
    logic [ADDR_W-1:0] ldaddr_data;
    logic              staddr_valid;
    logic              staddr_ready;
    logic [ADDR_W-1:0] staddr_data;
    logic              stdata_valid;
    logic              stdata_ready;
    logic [DATA_W-1:0] stdata_data;
    logic              mem_stdone_valid;
    logic              mem_stdone_ready;
    logic              mem_stdone_data;
    logic              stdone_valid;
    logic              stdone_ready;
    logic              stdone_data;

    modport slave (
        input  in_ldaddr_valid, in_ldaddr_data,
        input  in_staddr_valid, in_staddr_data,
        input  in_stdata_valid, in_stdata_data,
        input  ldaddr_ready, staddr_ready, stdata_ready,
        input  mem_stdone_valid, mem_stdone_data, stdone_ready,
        output in_ldaddr_ready, in_staddr_ready, in_stdata_ready,
        output ldaddr_valid, ldaddr_data,
        output staddr_valid, staddr_data,
        output stdata_valid, stdata_data,
        output mem_stdone_ready, stdone_valid, stdone_data
    );

    modport master (
        output in_ldaddr_valid, in_ldaddr_data,
        output in_staddr_valid, in_staddr_data,
        output in_stdata_valid, in_stdata_data,
        output ldaddr_ready, staddr_ready, stdata_ready,
        output mem_stdone_valid, mem_stdone_data, stdone_ready,
        input  in_ldaddr_ready, in_staddr_ready, in_stdata_ready,
        input  ldaddr_valid, ldaddr_data,
        input  staddr_valid, staddr_data,
        input  stdata_valid, stdata_data,
        input  mem_stdone_ready, stdone_valid, stdone_data
    );
endinterface

// File: rtl/memory_ldst_frontend.sv
// Load/store request front end: decoupled store address/data queues, paired
// store issue, in-flight store tracking and read-after-write load stalling.
module memory_ldst_frontend #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int SQ_DEPTH  = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    memory_ldst_frontend_if.slave          bus,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_count,
    output logic                           error_valid,
    output logic [15:0]                    error_code
);
    localparam int SPW = $clog2(SQ_DEPTH);
    localparam int OPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(MAX_OUTST + 1);
    localparam logic [SPW-1:0] SQ_LAST = SPW'(SQ_DEPTH - 1);
    localparam logic [SPW-1:0] SQ_ONE  = SPW'(1);
    localparam logic [OPW-1:0] OT_LAST = OPW'(MAX_OUTST - 1);
    localparam logic [OPW-1:0] OT_ONE  = OPW'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTST);

    function automatic logic [SPW-1:0] sq_inc(input logic [SPW-1:0] p);
        if (p == SQ_LAST) sq_inc = {SPW{1'b0}};
        else              sq_inc = p + SQ_ONE;
    endfunction

    function automatic logic [OPW-1:0] ot_inc(input logic [OPW-1:0] p);
        if (p == OT_LAST) ot_inc = {OPW{1'b0}};
        else              ot_inc = p + OT_ONE;
    endfunction

    logic [ADDR_W-1:0]  saq_mem_q [SQ_DEPTH];
    logic [ADDR_W-1:0]  saq_mem_d [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] saq_vld_q, saq_vld_d;
    logic [SPW-1:0]     saq_wp_q, saq_wp_d, saq_rp_q, saq_rp_d;
    logic [DATA_W-1:0]  sdq_mem_q [SQ_DEPTH];
    logic [DATA_W-1:0]  sdq_mem_d [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] sdq_vld_q, sdq_vld_d;
    logic [SPW-1:0]     sdq_wp_q, sdq_wp_d, sdq_rp_q, sdq_rp_d;
    logic [ADDR_W-1:0]  ot_mem_q [MAX_OUTST];
    logic [ADDR_W-1:0]  ot_mem_d [MAX_OUTST];
    logic [MAX_OUTST-1:0] ot_vld_q, ot_vld_d;
    logic [OPW-1:0]     ot_wp_q, ot_wp_d, ot_rp_q, ot_rp_d;
    logic [CW-1:0]      ot_cnt_q, ot_cnt_d;
    logic               sa_sent_q, sa_sent_d, sd_sent_q, sd_sent_d;
    logic               err_vld_q, err_vld_d;
    logic [15:0]        err_code_q, err_code_d;

    logic issue_ok_s, sa_push_s, sd_push_s, sa_hs_s, sd_hs_s, retire_s;
    logic done_hs_s, ot_pop_s, spurious_s, hazard_s;

    // A started pair keeps issuing until both halves are accepted.
    assign issue_ok_s = sa_sent_q | sd_sent_q |
                        (saq_vld_q[saq_rp_q] & sdq_vld_q[sdq_rp_q] & (ot_cnt_q < CNT_MAX));

    assign bus.in_staddr_ready = ~saq_vld_q[saq_wp_q] & ~rst;
    assign bus.in_stdata_ready = ~sdq_vld_q[sdq_wp_q] & ~rst;
    assign bus.staddr_valid    = issue_ok_s & ~sa_sent_q & ~rst;
    assign bus.stdata_valid    = issue_ok_s & ~sd_sent_q & ~rst;
    assign bus.staddr_data     = saq_mem_q[saq_rp_q];
    assign bus.stdata_data     = sdq_mem_q[sdq_rp_q];

    assign sa_push_s  = bus.in_staddr_valid & bus.in_staddr_ready;
    assign sd_push_s  = bus.in_stdata_valid & bus.in_stdata_ready;
    assign sa_hs_s    = bus.staddr_valid & bus.staddr_ready;
    assign sd_hs_s    = bus.stdata_valid & bus.stdata_ready;
    assign retire_s   = (sa_sent_q | sa_hs_s) & (sd_sent_q | sd_hs_s);

    assign bus.stdone_valid     = bus.mem_stdone_valid & ~rst;
    assign bus.stdone_data      = bus.mem_stdone_data;
    assign bus.mem_stdone_ready = bus.stdone_ready & ~rst;
    assign done_hs_s  = bus.stdone_valid & bus.stdone_ready;
    assign ot_pop_s   = done_hs_s & (ot_cnt_q != {CW{1'b0}});
    assign spurious_s = done_hs_s & (ot_cnt_q == {CW{1'b0}});

    // Load hazard: match against every queued or in-flight store address.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            hazard_s = hazard_s | (saq_vld_q[i] & (saq_mem_q[i] == bus.in_ldaddr_data));
        end
        for (int j = 0; j < MAX_OUTST; j++) begin
            hazard_s = hazard_s | (ot_vld_q[j] & (ot_mem_q[j] == bus.in_ldaddr_data));
        end
    end

    assign bus.ldaddr_valid    = bus.in_ldaddr_valid & ~hazard_s & ~rst;
    assign bus.in_ldaddr_ready = bus.ldaddr_ready & ~hazard_s & ~rst;
    assign bus.ldaddr_data     = bus.in_ldaddr_data;

    assign outst_count = rst ? {CW{1'b0}} : ot_cnt_q;
    assign error_valid = err_vld_q & ~rst;
    assign error_code  = rst ? 16'h0000 : err_code_q;

    // Next-state for queues, in-flight table, sent bits and error capture.
    always_comb begin
        saq_mem_d = saq_mem_q;  saq_vld_d = saq_vld_q;
        saq_wp_d  = saq_wp_q;   saq_rp_d  = saq_rp_q;
        sdq_mem_d = sdq_mem_q;  sdq_vld_d = sdq_vld_q;
        sdq_wp_d  = sdq_wp_q;   sdq_rp_d  = sdq_rp_q;
        ot_mem_d  = ot_mem_q;   ot_vld_d  = ot_vld_q;
        ot_wp_d   = ot_wp_q;    ot_rp_d   = ot_rp_q;
        sa_sent_d = sa_sent_q;  sd_sent_d = sd_sent_q;
        err_vld_d = err_vld_q;  err_code_d = err_code_q;

        if (ot_pop_s) begin
            ot_vld_d[ot_rp_q] = 1'b0;
            ot_rp_d           = ot_inc(ot_rp_q);
        end else begin
            ot_rp_d = ot_rp_q;
        end

        if (retire_s) begin
            saq_vld_d[saq_rp_q] = 1'b0;
            saq_rp_d            = sq_inc(saq_rp_q);
            sdq_vld_d[sdq_rp_q] = 1'b0;
            sdq_rp_d            = sq_inc(sdq_rp_q);
            ot_mem_d[ot_wp_q]   = saq_mem_q[saq_rp_q];
            ot_vld_d[ot_wp_q]   = 1'b1;
            ot_wp_d             = ot_inc(ot_wp_q);
            sa_sent_d           = 1'b0;
            sd_sent_d           = 1'b0;
        end else begin
            sa_sent_d = sa_sent_q | sa_hs_s;
            sd_sent_d = sd_sent_q | sd_hs_s;
        end

        if (sa_push_s) begin
            saq_mem_d[saq_wp_q] = bus.in_staddr_data;
            saq_vld_d[saq_wp_q] = 1'b1;
            saq_wp_d            = sq_inc(saq_wp_q);
        end else begin
            saq_wp_d = saq_wp_q;
        end

        if (sd_push_s) begin
            sdq_mem_d[sdq_wp_q] = bus.in_stdata_data;
            sdq_vld_d[sdq_wp_q] = 1'b1;
            sdq_wp_d            = sq_inc(sdq_wp_q);
        end else begin
            sdq_wp_d = sdq_wp_q;
        end

        case ({retire_s, ot_pop_s})
            2'b10:   ot_cnt_d = ot_cnt_q + CNT_ONE;
            2'b01:   ot_cnt_d = ot_cnt_q - CNT_ONE;
            default: ot_cnt_d = ot_cnt_q;
        endcase

        if (spurious_s && !err_vld_q) begin
            err_vld_d  = 1'b1;
            err_code_d = 16'h0001;
        end else begin
            err_vld_d  = err_vld_q;
            err_code_d = err_code_q;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            saq_vld_q  <= {SQ_DEPTH{1'b0}};
            saq_wp_q   <= {SPW{1'b0}};
            saq_rp_q   <= {SPW{1'b0}};
            sdq_vld_q  <= {SQ_DEPTH{1'b0}};
            sdq_wp_q   <= {SPW{1'b0}};
            sdq_rp_q   <= {SPW{1'b0}};
            ot_vld_q   <= {MAX_OUTST{1'b0}};
            ot_wp_q    <= {OPW{1'b0}};
            ot_rp_q    <= {OPW{1'b0}};
            ot_cnt_q   <= {CW{1'b0}};
            sa_sent_q  <= 1'b0;
            sd_sent_q  <= 1'b0;
            err_vld_q  <= 1'b0;
            err_code_q <= 16'h0000;
        end else begin
            saq_vld_q  <= saq_vld_d;
            saq_wp_q   <= saq_wp_d;
            saq_rp_q   <= saq_rp_d;
            sdq_vld_q  <= sdq_vld_d;
            sdq_wp_q   <= sdq_wp_d;
            sdq_rp_q   <= sdq_rp_d;
            ot_vld_q   <= ot_vld_d;
            ot_wp_q    <= ot_wp_d;
            ot_rp_q    <= ot_rp_d;
            ot_cnt_q   <= ot_cnt_d;
            sa_sent_q  <= sa_sent_d;
            sd_sent_q  <= sd_sent_d;
            err_vld_q  <= err_vld_d;
            err_code_q <= err_code_d;
        end
    end

    // Entry storage; contents are qualified by the valid bits above.
    always_ff @(posedge clk) begin
        saq_mem_q <= saq_mem_d;
        sdq_mem_q <= sdq_mem_d;
        ot_mem_q  <= ot_mem_d;
    end
endmodule

// File: tb/tb_memory_ldst_frontend.sv
// Self-checking bench for memory_ldst_frontend: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_memory_ldst_frontend;
    localparam int ADDR_W = 64, DATA_W = 32, SQ_DEPTH = 4, MAX_OUTST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  outst_count;
    logic        error_valid;
    logic [15:0] error_code;
    int checks = 0;
    int failures = 0;

    memory_ldst_frontend_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    memory_ldst_frontend #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SQ_DEPTH(SQ_DEPTH),
                           .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst), .bus(bus), .outst_count(outst_count),
        .error_valid(error_valid), .error_code(error_code));

    always #5 clk = ~clk;

    // Reference model: plain queues for SAQ, SDQ and in-flight stores
    logic [ADDR_W-1:0] m_saq[$];
    logic [DATA_W-1:0] m_sdq[$];
    logic [ADDR_W-1:0] m_infl[$];
    bit                m_sa_sent, m_sd_sent, m_err;
    logic [15:0]       m_errc;
    bit e_in_sa_rdy, e_in_sd_rdy, e_sa_vld, e_sd_vld, e_ld_vld, e_in_ld_rdy, e_done_vld, e_mdone_rdy;
    logic [ADDR_W-1:0] e_sa_data;
    logic [DATA_W-1:0] e_sd_data;

    task automatic model_eval();
        bit hz, pair_on;
        hz = 1'b0;
        foreach (m_saq[i])  if (m_saq[i] == bus.in_ldaddr_data)  hz = 1'b1;
        foreach (m_infl[i]) if (m_infl[i] == bus.in_ldaddr_data) hz = 1'b1;
        pair_on = m_sa_sent || m_sd_sent ||
                  (m_saq.size() > 0 && m_sdq.size() > 0 && m_infl.size() < MAX_OUTST);
        e_in_sa_rdy = !rst && (m_saq.size() < SQ_DEPTH);
        e_in_sd_rdy = !rst && (m_sdq.size() < SQ_DEPTH);
        e_sa_vld    = !rst && pair_on && !m_sa_sent;
        e_sd_vld    = !rst && pair_on && !m_sd_sent;
        e_sa_data   = (m_saq.size() > 0) ? m_saq[0] : 64'd0;
        e_sd_data   = (m_sdq.size() > 0) ? m_sdq[0] : 32'd0;
        e_ld_vld    = !rst && bus.in_ldaddr_valid && !hz;
        e_in_ld_rdy = !rst && bus.ldaddr_ready && !hz;
        e_done_vld  = !rst && bus.mem_stdone_valid;
        e_mdone_rdy = !rst && bus.stdone_ready;
    endtask

    task automatic advance();
        bit sa_hs, sd_hs, ret, done_hs, pa, pd;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        model_eval();
        sa_hs   = e_sa_vld && bus.staddr_ready;
        sd_hs   = e_sd_vld && bus.stdata_ready;
        ret     = (m_sa_sent || sa_hs) && (m_sd_sent || sd_hs);
        done_hs = e_done_vld && bus.stdone_ready;
        pa = bus.in_staddr_valid && e_in_sa_rdy;
        pd = bus.in_stdata_valid && e_in_sd_rdy;
        a  = bus.in_staddr_data;
        d  = bus.in_stdata_data;
        @(posedge clk);
        if (rst) begin
            m_saq.delete(); m_sdq.delete(); m_infl.delete();
            m_sa_sent = 1'b0; m_sd_sent = 1'b0; m_err = 1'b0; m_errc = 16'h0000;
        end else begin
            if (done_hs) begin
                if (m_infl.size() > 0) void'(m_infl.pop_front());
                else if (!m_err) begin m_err = 1'b1; m_errc = 16'h0001; end
            end
            if (ret) begin
                m_infl.push_back(m_saq.pop_front());
                void'(m_sdq.pop_front());
                m_sa_sent = 1'b0; m_sd_sent = 1'b0;
            end else begin
                if (sa_hs) m_sa_sent = 1'b1;
                if (sd_hs) m_sd_sent = 1'b1;
            end
            if (pa) m_saq.push_back(a);
            if (pd) m_sdq.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_ldaddr_valid = 1'b0; bus.in_ldaddr_data = 64'd0;
        bus.in_staddr_valid = 1'b0; bus.in_staddr_data = 64'd0;
        bus.in_stdata_valid = 1'b0; bus.in_stdata_data = 32'd0;
        bus.mem_stdone_valid = 1'b0; bus.mem_stdone_data = 1'b1;
        bus.ldaddr_ready = 1'b1; bus.staddr_ready = 1'b1;
        bus.stdata_ready = 1'b1; bus.stdone_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        advance(); advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] allv;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_ldaddr_valid = 1'($urandom); bus.in_ldaddr_data = {$urandom, $urandom};
            bus.in_staddr_valid = 1'($urandom); bus.in_staddr_data = {$urandom, $urandom};
            bus.in_stdata_valid = 1'($urandom); bus.in_stdata_data = $urandom;
            bus.mem_stdone_valid = 1'($urandom); bus.mem_stdone_data = 1'($urandom);
            bus.ldaddr_ready = 1'($urandom); bus.staddr_ready = 1'($urandom);
            bus.stdata_ready = 1'($urandom); bus.stdone_ready = 1'($urandom);
            #1;
            allv = {bus.in_ldaddr_ready, bus.in_staddr_ready, bus.in_stdata_ready, bus.ldaddr_valid,
                    bus.staddr_valid, bus.stdata_valid, bus.mem_stdone_ready, bus.stdone_valid,
                    outst_count, error_valid};
            checks++;
            if (allv !== 12'd0) begin failures++; $display("FAIL reset_outputs cyc=%0d got=%h exp=000", c, allv); end
            checks++;
            if (error_code !== 16'h0000) begin failures++; $display("FAIL reset_error_code got=%h exp=0000", error_code); end
            advance();
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({bus.in_staddr_ready, bus.in_stdata_ready} !== 2'b11) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=11", {bus.in_staddr_ready, bus.in_stdata_ready});
        end
        advance();
    endtask

    task automatic test_decoupled();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            bus.in_staddr_valid  = (c == 2); bus.in_staddr_data = 64'h100;
            bus.in_stdata_valid  = (c == 6); bus.in_stdata_data = 32'hDEADBEEF;
            bus.mem_stdone_valid = (c == 9);
            #1;
            if (c >= 3 && c <= 6) begin
                checks++;
                if (bus.staddr_valid !== 1'b0) begin failures++; $display("FAIL dec_early_issue cyc=%0d got=1 exp=0", c); end
            end
            if (c == 7) begin
                checks++;
                if ({bus.staddr_valid, bus.stdata_valid} !== 2'b11) begin
                    failures++; $display("FAIL dec_issue_valid got=%b exp=11", {bus.staddr_valid, bus.stdata_valid});
                end
                checks++;
                if (bus.staddr_data !== 64'h100 || bus.stdata_data !== 32'hDEADBEEF) begin
                    failures++; $display("FAIL dec_issue_data got=%h/%h exp=100/deadbeef", bus.staddr_data, bus.stdata_data);
                end
            end
            if (c == 8) begin
                checks++;
                if (outst_count !== 3'd1) begin failures++; $display("FAIL dec_outst_one got=%0d exp=1", outst_count); end
            end
            if (c == 10) begin
                checks++;
                if (outst_count !== 3'd0) begin failures++; $display("FAIL dec_outst_zero got=%0d exp=0", outst_count); end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] addrs [5];
        logic [DATA_W-1:0] datas [5];
        int sa_k = 0, sd_k = 0;
        do_reset();
        bus.staddr_ready = 1'b0; bus.stdata_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addrs[i] = {$urandom, $urandom}; datas[i] = $urandom;
            bus.in_staddr_valid = 1'b1; bus.in_staddr_data = addrs[i];
            bus.in_stdata_valid = (i < 4); bus.in_stdata_data = datas[i];
            #1;
            checks++;
            if (bus.in_staddr_ready !== (i < 4)) begin
                failures++; $display("FAIL bp_full_ready push=%0d got=%b exp=%b", i, bus.in_staddr_ready, (i < 4));
            end
            advance();
        end
        bus.in_staddr_valid = 1'b0; bus.in_stdata_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.staddr_ready = c[0]; bus.stdata_ready = !c[0];
            #1;
            if (bus.staddr_valid && bus.staddr_ready) begin
                checks++;
                if (sa_k > 3 || bus.staddr_data !== addrs[sa_k & 3]) begin
                    failures++; $display("FAIL bp_addr_order k=%0d got=%h exp=%h", sa_k, bus.staddr_data, addrs[sa_k & 3]);
                end
                sa_k++;
            end
            if (bus.stdata_valid && bus.stdata_ready) begin
                checks++;
                if (sd_k > 3 || bus.stdata_data !== datas[sd_k & 3]) begin
                    failures++; $display("FAIL bp_data_order k=%0d got=%h exp=%h", sd_k, bus.stdata_data, datas[sd_k & 3]);
                end
                sd_k++;
            end
            advance();
        end
        #1;
        checks++;
        if (sa_k != 4 || sd_k != 4 || outst_count !== 3'd4) begin
            failures++; $display("FAIL bp_retires got=%0d/%0d/%0d exp=4/4/4", sa_k, sd_k, outst_count);
        end
        advance();
    endtask

    task automatic test_outst_cap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_staddr_valid = 1'b1; bus.in_staddr_data = 64'h4000 + 64'(i * 16);
            bus.in_stdata_valid = 1'b1; bus.in_stdata_data = $urandom;
            advance();
        end
        bus.in_staddr_valid = 1'b0; bus.in_stdata_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.staddr_valid !== 1'b0 || outst_count !== 3'd4) begin
                failures++; $display("FAIL cap_held cyc=%0d got=%b/%0d exp=0/4", c, bus.staddr_valid, outst_count);
            end
            advance();
        end
        bus.mem_stdone_valid = 1'b1;
        #1;
        checks++;
        if (bus.stdone_valid !== 1'b1 || bus.staddr_valid !== 1'b0) begin
            failures++; $display("FAIL cap_done_cycle got=%b/%b exp=1/0", bus.stdone_valid, bus.staddr_valid);
        end
        advance();
        bus.mem_stdone_valid = 1'b0;
        #1;
        checks++;
        if (outst_count !== 3'd3 || {bus.staddr_valid, bus.stdata_valid} !== 2'b11 || bus.staddr_data !== 64'h4040) begin
            failures++; $display("FAIL cap_fifth_issue got=%0d/%b/%h exp=3/11/4040", outst_count,
                                 {bus.staddr_valid, bus.stdata_valid}, bus.staddr_data);
        end
        advance();
        #1;
        checks++;
        if (outst_count !== 3'd4) begin failures++; $display("FAIL cap_refill got=%0d exp=4", outst_count); end
        advance();
    endtask

    task automatic test_hazard();
        do_reset();
        bus.in_staddr_valid = 1'b1; bus.in_staddr_data = 64'h200;
        advance();
        bus.in_staddr_valid = 1'b0;
        bus.in_ldaddr_valid = 1'b1; bus.in_ldaddr_data = 64'h200;
        #1;
        checks++;
        if ({bus.ldaddr_valid, bus.in_ldaddr_ready} !== 2'b00) begin
            failures++; $display("FAIL haz_queued got=%b exp=00", {bus.ldaddr_valid, bus.in_ldaddr_ready});
        end
        advance();
        bus.in_ldaddr_data = 64'h208;
        #1;
        checks++;
        if ({bus.ldaddr_valid, bus.in_ldaddr_ready} !== 2'b11 || bus.ldaddr_data !== 64'h208) begin
            failures++; $display("FAIL haz_other_addr got=%b/%h exp=11/208", {bus.ldaddr_valid, bus.in_ldaddr_ready}, bus.ldaddr_data);
        end
        advance();
        bus.in_ldaddr_data = 64'h200;
        for (int c = 0; c < 3; c++) begin
            bus.in_stdata_valid = (c == 0); bus.in_stdata_data = 32'h12345678;
            #1;
            checks++;
            if (bus.ldaddr_valid !== 1'b0) begin failures++; $display("FAIL haz_inflight cyc=%0d got=1 exp=0", c); end
            advance();
        end
        bus.mem_stdone_valid = 1'b1;
        #1;
        checks++;
        if (bus.ldaddr_valid !== 1'b0) begin failures++; $display("FAIL haz_done_cycle got=1 exp=0"); end
        advance();
        bus.mem_stdone_valid = 1'b0;
        #1;
        checks++;
        if (bus.ldaddr_valid !== 1'b1 || outst_count !== 3'd0) begin
            failures++; $display("FAIL haz_release got=%b/%0d exp=1/0", bus.ldaddr_valid, outst_count);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        bus.mem_stdone_valid = 1'b1;
        #1;
        checks++;
        if ({bus.stdone_valid, bus.mem_stdone_ready} !== 2'b11) begin
            failures++; $display("FAIL spur_passthru got=%b exp=11", {bus.stdone_valid, bus.mem_stdone_ready});
        end
        advance();
        bus.mem_stdone_valid = 1'b0;
        #1;
        checks++;
        if (error_valid !== 1'b1 || error_code !== 16'h0001 || outst_count !== 3'd0) begin
            failures++; $display("FAIL spur_first got=%b/%h/%0d exp=1/0001/0", error_valid, error_code, outst_count);
        end
        advance();
        bus.mem_stdone_valid = 1'b1;
        advance();
        bus.mem_stdone_valid = 1'b0;
        #1;
        checks++;
        if (error_valid !== 1'b1 || error_code !== 16'h0001 || outst_count !== 3'd0) begin
            failures++; $display("FAIL spur_second got=%b/%h/%0d exp=1/0001/0", error_valid, error_code, outst_count);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.in_staddr_valid = 1'($urandom);
            bus.in_staddr_data  = 64'h1000 + {58'd0, 3'($urandom_range(0, 7)), 3'd0};
            bus.in_stdata_valid = 1'($urandom);
            bus.in_stdata_data  = $urandom;
            bus.in_ldaddr_valid = 1'($urandom);
            bus.in_ldaddr_data  = 64'h1000 + {58'd0, 3'($urandom_range(0, 7)), 3'd0};
            bus.ldaddr_ready = 1'($urandom); bus.staddr_ready = 1'($urandom);
            bus.stdata_ready = 1'($urandom); bus.stdone_ready = ($urandom_range(0, 3) != 0);
            bus.mem_stdone_valid = (m_infl.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
            bus.mem_stdone_data  = 1'($urandom);
            #1;
            model_eval();
            checks++;
            if ({bus.in_staddr_ready, bus.in_stdata_ready, bus.staddr_valid, bus.stdata_valid} !==
                {e_in_sa_rdy, e_in_sd_rdy, e_sa_vld, e_sd_vld}) begin
                failures++; $display("FAIL rnd_store_ctl cyc=%0d got=%b exp=%b", c,
                    {bus.in_staddr_ready, bus.in_stdata_ready, bus.staddr_valid, bus.stdata_valid},
                    {e_in_sa_rdy, e_in_sd_rdy, e_sa_vld, e_sd_vld});
            end
            if (e_sa_vld) begin
                checks++;
                if (bus.staddr_data !== e_sa_data) begin failures++; $display("FAIL rnd_staddr cyc=%0d got=%h exp=%h", c, bus.staddr_data, e_sa_data); end
            end
            if (e_sd_vld) begin
                checks++;
                if (bus.stdata_data !== e_sd_data) begin failures++; $display("FAIL rnd_stdata cyc=%0d got=%h exp=%h", c, bus.stdata_data, e_sd_data); end
            end
            checks++;
            if ({bus.ldaddr_valid, bus.in_ldaddr_ready} !== {e_ld_vld, e_in_ld_rdy}) begin
                failures++; $display("FAIL rnd_load cyc=%0d addr=%h got=%b exp=%b", c, bus.in_ldaddr_data,
                    {bus.ldaddr_valid, bus.in_ldaddr_ready}, {e_ld_vld, e_in_ld_rdy});
            end
            if (e_ld_vld) begin
                checks++;
                if (bus.ldaddr_data !== bus.in_ldaddr_data) begin failures++; $display("FAIL rnd_ldaddr cyc=%0d got=%h exp=%h", c, bus.ldaddr_data, bus.in_ldaddr_data); end
            end
            checks++;
            if ({bus.stdone_valid, bus.mem_stdone_ready} !== {e_done_vld, e_mdone_rdy} ||
                (e_done_vld && bus.stdone_data !== bus.mem_stdone_data)) begin
                failures++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, {bus.stdone_valid, bus.mem_stdone_ready}, {e_done_vld, e_mdone_rdy});
            end
            checks++;
            if (outst_count !== (rst ? 3'd0 : 3'(m_infl.size())) ||
                error_valid !== (m_err && !rst) || error_code !== (rst ? 16'h0000 : m_errc)) begin
                failures++; $display("FAIL rnd_status cyc=%0d got=%0d/%b/%h exp=%0d/%b/%h", c, outst_count, error_valid,
                    error_code, rst ? 0 : m_infl.size(), m_err && !rst, rst ? 16'h0000 : m_errc);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_errc = 16'h0000;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_decoupled();
        test_backpressure();
        test_outst_cap();
        test_hazard();
        test_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
